// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit, timed by baud_tick.
// Latency: stop bit sampled MID + OVERSAMPLE*(DATA_BITS+1) ticks after start detect; rx_valid/frame_err one clk later.
// Backpressure: none; rx_data is overwritten by each new frame and must be taken on rx_valid.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   baud_tick   one-clk pulse, OVERSAMPLE pulses per bit period
//   rx_line     asynchronous serial input, idle high
//   rx_data     last correctly framed word (LSB = first bit received)
//   rx_valid    one-clk pulse when rx_data updates
//   frame_err   one-clk pulse when the stop bit is sampled low
//   busy        high whenever the receiver is not idle
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MID    = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_meta_q, rx_s_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_line;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        // Pulses are cleared every clk, not only on ticks, so they stay one clk wide.
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    // Only the mid-bit sample decides; earlier glitches are ignored.
                    if (tick_cnt_q == TICK_W'(MID - 1)) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        // LSB arrives first: shift right, new bit enters at the MSB.
                        shift_d = shift_q >> 1;
                        shift_d[DATA_BITS-1] = rx_s_q;
                        if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high so a held-low line cannot restart a frame.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int tick_div = 4;

    // Monitor bookkeeping
    logic [7:0] rx_q[$];
    int         ferr_cnt  = 0;
    int         viol_cnt  = 0;
    logic       prev_vld  = 1'b0;
    logic       prev_ferr = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_line   (rx_line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick generator: one tick every tick_div clocks, changed on the falling edge.
    initial begin
        int tcnt;
        tcnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            if (tcnt >= tick_div) begin
                baud_tick = 1'b1;
                tcnt = 0;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    // Output monitor, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) rx_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (rx_valid && frame_err) viol_cnt++;
            if (rx_valid && prev_vld) viol_cnt++;
            if (frame_err && prev_ferr) viol_cnt++;
            prev_vld  = rx_valid;
            prev_ferr = frame_err;
        end
    end

    // Watchdog: every wait is tick-bounded, this only catches a stalled run.
    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int nticks);
        @(negedge clk);
        rx_line = b;
        wait_ticks(nticks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(stop, 16);
    endtask

    initial begin
        logic [7:0] exp_b2b [3];
        int         mism;
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h55;

        rst     = 1'b1;
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data",   rx_data,   8'h00);
        check("reset_rx_valid",  rx_valid,  1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy",      busy,      1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);

        // 1: single frame 0xA5
        rx_q.delete();
        send_frame(8'hA5, 1'b1);
        wait_ticks(2);
        check("t1_valid_count", rx_q.size(), 1);
        check("t1_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
        check("t1_ferr_count", ferr_cnt, 0);
        check("t1_busy_after", busy, 1'b0);

        // 3: false start, low for 4 ticks only
        rx_q.delete();
        send_bit(1'b0, 4);
        check("t3_busy_detect", busy, 1'b1);
        send_bit(1'b1, 8);
        check("t3_busy_dropped", busy, 1'b0);
        check("t3_no_valid", rx_q.size(), 0);
        check("t3_no_ferr", ferr_cnt, 0);

        // 4: 0x3C with stop low, line held low 40 ticks, then 0x81
        rx_q.delete();
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(8'h3C >> i & 8'h01, 16);
        send_bit(1'b0, 40);
        check("t4_ferr_count", ferr_cnt, 1);
        check("t4_no_valid", rx_q.size(), 0);
        check("t4_data_kept", rx_data, 8'hA5);
        check("t4_busy_break", busy, 1'b1);
        send_bit(1'b1, 4);
        check("t4_busy_released", busy, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_ticks(2);
        check("t4_recover_count", rx_q.size(), 1);
        check("t4_recover_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h81);

        // 2: back-to-back 0x00, 0xFF, 0x55
        rx_q.delete();
        for (int k = 0; k < 3; k++) send_frame(exp_b2b[k], 1'b1);
        wait_ticks(2);
        check("t2_valid_count", rx_q.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("t2_data%0d", k), (rx_q.size() > k) ? rx_q[k] : 8'hxx, exp_b2b[k]);
        check("t2_ferr_count", ferr_cnt, 1);

        // 5: reset in the middle of data bit 3 of 0xC3, then 0x7E
        rx_q.delete();
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(8'hC3 >> i & 8'h01, 16);
        send_bit(1'b0, 8);
        check("t5_busy_before_rst", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_rx_data",   rx_data,   8'h00);
        check("t5_rst_rx_valid",  rx_valid,  1'b0);
        check("t5_rst_frame_err", frame_err, 1'b0);
        check("t5_rst_busy",      busy,      1'b0);
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(20);
        check("t5_idle_after_rst", busy, 1'b0);
        send_frame(8'h7E, 1'b1);
        wait_ticks(2);
        check("t5_valid_count", rx_q.size(), 1);
        check("t5_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h7E);

        // 6: loopback-style stream of all 256 values, tick every clock
        tick_div = 1;
        wait_ticks(4);
        rx_q.delete();
        for (int v = 0; v < 256; v++) send_frame(8'(v), 1'b1);
        wait_ticks(4);
        mism = 0;
        for (int v = 0; v < 256; v++)
            if (rx_q.size() <= v || rx_q[v] !== 8'(v)) mism++;
        check("t6_valid_count", rx_q.size(), 256);
        check("t6_mismatches", mism, 0);
        check("t6_ferr_count", ferr_cnt, 1);
        check("pulse_rules", viol_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
